cla_seq_adder: RTL and testbench
================================

Name: cla_seq_adder

Overview:
Multi-cycle wide adder built around one shared 4-bit carry_lookahead_adder instance (ports a, b, c_in, s, c_out). Accepts a 4*WORDS-bit operand pair through a valid/ready handshake. Feeds one 4-bit slice per cycle, LSB slice first, through the CLA and registers the inter-slice carry. Presents the assembled sum, carry-out and signed-overflow flag through an output valid/ready handshake. Lets datapaths wider than 4 bits reuse the verified 4-bit CLA without replicating it.

Parameters:
WORDS, 4, number of 4-bit slices; operand width W = 4*WORDS; legal range WORDS >= 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair offered
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  W  operand A
b  input  W  operand B
c_in  input  1  carry-in to slice 0
out_valid  output  1  result held and valid
out_ready  input  1  consumer takes result
sum  output  W  result, mod 2^W
c_out  output  1  carry out of top slice
ovf  output  1  two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async on rst_n low, any state): state=IDLE, slice index=0, carry reg=0, operand regs=0, sum=0, c_out=0, ovf=0, out_valid=0, busy=0, in_ready=1 (combinational from state). Reset mid-operation aborts the operation; no partial result is ever presented.
- Slice index counter width is max(1, clog2(WORDS)).
- IDLE: in_ready=1. On edge with in_valid=1, capture a, b, c_in into operand regs; carry reg<=c_in; idx<=0; sum<=0; go to RUN.
- RUN: in_ready=0, busy=1. CLA is driven combinationally: a = A_reg[4*idx+:4], b = B_reg[4*idx+:4], c_in = carry reg. Each edge: sum[4*idx+:4]<=s; carry reg<=c_out; idx<=idx+1. On the edge where idx==WORDS-1: c_out<=CLA c_out; ovf<=(A_reg[W-1]==B_reg[W-1]) && (s[3]!=A_reg[W-1]); out_valid<=1; go to DONE.
- Latency: accept edge T; out_valid rises after edge T+WORDS. WORDS=1 gives a single RUN cycle.
- DONE: out_valid=1; sum, c_out and ovf are held stable. in_valid is ignored. On edge with out_ready=1: out_valid<=0, go to IDLE. sum, c_out and ovf keep their values until the next accept.
- out_ready is ignored outside DONE. An operand is never accepted on the same edge as a result handoff. Throughput is one operation per WORDS+2 cycles minimum.
- Operand inputs may change freely after the accept edge; only the captured copies are used.
- busy = (state != IDLE).

Optional Feature:
- Macro: CLA_SEQ_SUB_EN.
- Defined: adds input port op_sub (1 bit), captured on the accept edge. When op_sub=1, the B_reg capture is ~b and the initial carry reg is 1 (c_in is ignored), giving sum = a - b mod 2^W. c_out=1 means no borrow. ovf uses the captured (inverted) B_reg MSB.
- Not defined: no op_sub port; add only.

Test Plan:
1. WORDS=4; a=16'hFFFF, b=16'h0001, c_in=1 -> out_valid exactly 4 cycles after accept; sum=16'h0001, c_out=1, ovf=0 (carry ripples through all slices).
2. a=16'h1234, b=16'h4321, c_in=0 -> sum=16'h5555, c_out=0, ovf=0. a=16'h7FFF, b=16'h0001, c_in=0 -> sum=16'h8000, c_out=0, ovf=1.
3. Backpressure: complete a=16'h0009, b=16'h0005, c_in=1, then hold out_ready=0 for 5 cycles while pulsing in_valid -> sum=16'h000F held, out_valid=1, in_ready=0, no new capture. Raise out_ready -> out_valid=0 next cycle, in_ready=1.
4. Reset mid-RUN: assert rst_n=0 two cycles after accept -> immediately sum=0, c_out=0, ovf=0, out_valid=0, busy=0. After release, in_ready=1 and the next operation (a=16'h0006, b=16'h0005) gives 16'h000B.
5. WORDS=1; a=4'hF, b=4'h1, c_in=1 -> out_valid 1 cycle after accept; sum=4'h1, c_out=1.
6. CLA_SEQ_SUB_EN defined, WORDS=4: op_sub=1, a=16'h0005, b=16'h0007, c_in=0 -> sum=16'hFFFE, c_out=0, ovf=0. op_sub=1, a=16'h8000, b=16'h0001 -> sum=16'h7FFF, c_out=1, ovf=1.

Source files
------------

// File: rtl/cla_seq_adder_if.sv
// Handshake and data bundle for cla_seq_adder: operand intake, result output, status.
// Optional CLA_SEQ_SUB_EN adds the op_sub request bit.
interface cla_seq_adder_if #(
   parameter int WORDS = 4
);
   localparam int W = 4 * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
`ifdef CLA_SEQ_SUB_EN
   logic         op_sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;
   logic         busy;

   modport slave (
      input  in_valid, a, b, c_in, out_ready,
`ifdef CLA_SEQ_SUB_EN
      input  op_sub,
`endif
      output in_ready, out_valid, sum, c_out, ovf, busy
   );

   modport master (
      output in_valid, a, b, c_in, out_ready,
`ifdef CLA_SEQ_SUB_EN
      output op_sub,
`endif
      input  in_ready, out_valid, sum, c_out, ovf, busy
   );
endinterface

// File: rtl/cla_seq_adder.sv
// Multi-cycle 4*WORDS-bit adder reusing one 4-bit carry-lookahead slice, LSB slice first.
// Define CLA_SEQ_SUB_EN to add subtraction via the op_sub interface bit.
module carry_lookahead_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] s,
   output logic       c_out
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g    = a & b;
   assign p    = a ^ b;
   assign c[0] = c_in;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);
   assign s     = p ^ c[3:0];
   assign c_out = c[4];
endmodule

module cla_seq_adder #(
   parameter int WORDS = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   cla_seq_adder_if.slave bus
);
   localparam int W  = 4 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_reg, state_next;
   logic [IW-1:0]  idx_reg, idx_next;
   logic           carry_reg, carry_next;
   logic [W-1:0]   a_reg, a_next;
   logic [W-1:0]   b_reg, b_next;
   logic [W-1:0]   sum_reg, sum_next;
   logic           c_out_reg, c_out_next;
   logic           ovf_reg, ovf_next;
   logic           out_valid_reg, out_valid_next;

   logic [3:0]     a_sl [WORDS];
   logic [3:0]     b_sl [WORDS];
   logic [3:0]     cla_a, cla_b, cla_s;
   logic           cla_c_out;
   logic           last_slice;
   logic [W-1:0]   b_cap;
   logic           cin_cap;

`ifdef CLA_SEQ_SUB_EN
   // Subtraction is a + ~b + 1; the caller's c_in is not used then.
   assign b_cap   = bus.op_sub ? ~bus.b : bus.b;
   assign cin_cap = bus.op_sub ? 1'b1 : bus.c_in;
`else
   assign b_cap   = bus.b;
   assign cin_cap = bus.c_in;
`endif

   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
         assign a_sl[gi] = a_reg[4*gi +: 4];
         assign b_sl[gi] = b_reg[4*gi +: 4];
      end
   endgenerate

   always_comb begin
      cla_a = '0;
      cla_b = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (idx_reg == IW'(i)) begin
            cla_a = a_sl[i];
            cla_b = b_sl[i];
         end
      end
   end

   carry_lookahead_adder u_cla (
      .a     (cla_a),
      .b     (cla_b),
      .c_in  (carry_reg),
      .s     (cla_s),
      .c_out (cla_c_out)
   );

   assign last_slice = (idx_reg == IW'(WORDS - 1));

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      carry_next     = carry_reg;
      a_next         = a_reg;
      b_next         = b_reg;
      sum_next       = sum_reg;
      c_out_next     = c_out_reg;
      ovf_next       = ovf_reg;
      out_valid_next = out_valid_reg;
      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               a_next     = bus.a;
               b_next     = b_cap;
               carry_next = cin_cap;
               idx_next   = '0;
               sum_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < WORDS; i++) begin
               if (idx_reg == IW'(i)) sum_next[4*i +: 4] = cla_s;
            end
            carry_next = cla_c_out;
            idx_next   = idx_reg + IW'(1);
            if (last_slice) begin
               c_out_next     = cla_c_out;
               // Overflow: operands share a sign that the top sum bit does not.
               ovf_next       = (a_reg[W-1] == b_reg[W-1]) && (cla_s[3] != a_reg[W-1]);
               out_valid_next = 1'b1;
               state_next     = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         carry_reg     <= 1'b0;
         a_reg         <= '0;
         b_reg         <= '0;
         sum_reg       <= '0;
         c_out_reg     <= 1'b0;
         ovf_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         carry_reg     <= carry_next;
         a_reg         <= a_next;
         b_reg         <= b_next;
         sum_reg       <= sum_next;
         c_out_reg     <= c_out_next;
         ovf_reg       <= ovf_next;
         out_valid_reg <= out_valid_next;
      end
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.out_valid = out_valid_reg;
   assign bus.sum       = sum_reg;
   assign bus.c_out     = c_out_reg;
   assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: WORDS=4 and WORDS=1 instances, scoreboard of expected results.
// Subtraction scenarios run when CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_adder;
   typedef struct packed {
      logic [15:0] sum;
      logic        c_out;
      logic        ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   res_t sb_q[$];
   logic [5:0] sb1_q[$];

   always #5 clk = ~clk;

   cla_seq_adder_if #(.WORDS(4)) bus4 ();
   cla_seq_adder_if #(.WORDS(1)) bus1 ();

   cla_seq_adder #(.WORDS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
   cla_seq_adder #(.WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                  input logic sub);
      logic [15:0] bb;
      logic [16:0] t;
      res_t r;
      bb = sub ? ~b : b;
      t  = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
      r.sum   = t[15:0];
      r.c_out = t[16];
      r.ovf   = (a[15] == bb[15]) && (t[15] != a[15]);
      return r;
   endfunction

   task automatic accept4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub);
      int n = 0;
      while (!bus4.in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      bus4.a = a; bus4.b = b; bus4.c_in = cin;
`ifdef CLA_SEQ_SUB_EN
      bus4.op_sub = sub;
`endif
      bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      bus4.a = 16'($urandom); bus4.b = 16'($urandom); bus4.c_in = 1'($urandom);
      sb_q.push_back(model(a, b, cin, sub));
   endtask

   task automatic wait_valid4(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1; cyc++;
      end while (!bus4.out_valid && cyc < 50);
   endtask

   task automatic release4();
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus4.in_ready, bus4.out_valid, bus4.busy} !== 3'b100) begin
         failures++; $display("FAIL reset_flags got=%b want=100", {bus4.in_ready, bus4.out_valid, bus4.busy});
      end
      checks++;
      if ({bus4.sum, bus4.c_out, bus4.ovf} !== 18'd0) begin
         failures++; $display("FAIL reset_result got=%h want=0", {bus4.sum, bus4.c_out, bus4.ovf});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Full transaction: accept, exact latency, result, handoff.
   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
      int   cyc;
      res_t e;
      accept4(a, b, cin, sub);
      wait_valid4(cyc);
      checks++;
      if (cyc !== 4) begin
         failures++; $display("FAIL %s_latency got=%0d want=4", name, cyc);
      end
      e = sb_q.pop_front();
      checks++;
      if ({bus4.sum, bus4.c_out, bus4.ovf} !== e) begin
         failures++;
         $display("FAIL %s_result got sum=%h c=%b v=%b want sum=%h c=%b v=%b", name,
                  bus4.sum, bus4.c_out, bus4.ovf, e.sum, e.c_out, e.ovf);
      end
      $display("txn %s a=%h b=%h cin=%b sub=%b -> sum=%h c_out=%b ovf=%b", name, a, b, cin, sub,
               bus4.sum, bus4.c_out, bus4.ovf);
      release4();
      checks++;
      if ({bus4.out_valid, bus4.in_ready, bus4.busy} !== 3'b010) begin
         failures++;
         $display("FAIL %s_handoff got=%b want=010", name, {bus4.out_valid, bus4.in_ready, bus4.busy});
      end
   endtask

   task automatic test_ripple();
      run_op("ripple", 16'hFFFF, 16'h0001, 1'b1, 1'b0);
   endtask

   task automatic test_patterns();
      logic [15:0] ta [5] = '{16'h1234, 16'h7FFF, 16'hA5A5, 16'h0000, 16'h8000};
      logic [15:0] tb [5] = '{16'h4321, 16'h0001, 16'h5A5A, 16'h0000, 16'h8000};
      logic        tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) run_op("pattern", ta[i], tb[i], tc[i], 1'b0);
      run_op("random", 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
   endtask

   task automatic test_reset_mid_run();
      void'(sb_q.size());
      accept4(16'h1111, 16'h2222, 1'b0, 1'b0);
      void'(sb_q.pop_back());
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (bus4.busy !== 1'b1) begin
         failures++; $display("FAIL midrun_busy got=%b want=1", bus4.busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus4.sum, bus4.c_out, bus4.ovf} !== 18'd0) begin
         failures++; $display("FAIL midrun_reset_result got=%h want=0", {bus4.sum, bus4.c_out, bus4.ovf});
      end
      checks++;
      if ({bus4.out_valid, bus4.busy, bus4.in_ready} !== 3'b001) begin
         failures++;
         $display("FAIL midrun_reset_flags got=%b want=001", {bus4.out_valid, bus4.busy, bus4.in_ready});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         checks++;
         if (bus4.out_valid !== 1'b0) begin
            failures++; $display("FAIL midrun_no_partial got=%b want=0", bus4.out_valid);
         end
      end
      run_op("after_reset", 16'h0006, 16'h0005, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      int   cyc;
      res_t e;
      accept4(16'h0009, 16'h0005, 1'b1, 1'b0);
      wait_valid4(cyc);
      checks++;
      if (cyc !== 4) begin
         failures++; $display("FAIL bp_latency got=%0d want=4", cyc);
      end
      e = sb_q.pop_front();
      for (int k = 0; k < 5; k++) begin
         bus4.a = 16'hFFFF; bus4.b = 16'h00FF; bus4.in_valid = ~k[0];
         bus4.out_ready = 1'b0;
         @(posedge clk); #1;
         checks++;
         if ({bus4.sum, bus4.c_out, bus4.ovf} !== e) begin
            failures++; $display("FAIL bp_hold got=%h want=%h", {bus4.sum, bus4.c_out, bus4.ovf}, e);
         end
         checks++;
         if ({bus4.out_valid, bus4.in_ready} !== 2'b10) begin
            failures++; $display("FAIL bp_flags got=%b want=10", {bus4.out_valid, bus4.in_ready});
         end
      end
      bus4.in_valid = 1'b0;
      $display("txn backpressure sum=%h held", bus4.sum);
      release4();
      checks++;
      if ({bus4.out_valid, bus4.in_ready} !== 2'b01) begin
         failures++; $display("FAIL bp_release got=%b want=01", {bus4.out_valid, bus4.in_ready});
      end
      checks++;
      if (bus4.sum !== e.sum) begin
         failures++; $display("FAIL bp_sum_kept got=%h want=%h", bus4.sum, e.sum);
      end
   endtask

   task automatic test_words1();
      logic [3:0] ta [2] = '{4'hF, 4'h7};
      logic [3:0] tb [2] = '{4'h1, 4'h1};
      logic       tc [2] = '{1'b1, 1'b0};
      logic [4:0] t;
      logic [5:0] e;
      int         cyc;
      for (int i = 0; i < 2; i++) begin
         bus1.a = ta[i]; bus1.b = tb[i]; bus1.c_in = tc[i]; bus1.in_valid = 1'b1;
         @(posedge clk); #1;
         bus1.in_valid = 1'b0;
         t = {1'b0, ta[i]} + {1'b0, tb[i]} + {4'd0, tc[i]};
         sb1_q.push_back({t[3:0], t[4], (ta[i][3] == tb[i][3]) && (t[3] != ta[i][3])});
         cyc = 0;
         do begin
            @(posedge clk); #1; cyc++;
         end while (!bus1.out_valid && cyc < 20);
         checks++;
         if (cyc !== 1) begin
            failures++; $display("FAIL w1_latency got=%0d want=1", cyc);
         end
         e = sb1_q.pop_front();
         checks++;
         if ({bus1.sum, bus1.c_out, bus1.ovf} !== e) begin
            failures++; $display("FAIL w1_result got=%b want=%b", {bus1.sum, bus1.c_out, bus1.ovf}, e);
         end
         $display("txn w1 a=%h b=%h cin=%b -> sum=%h c_out=%b ovf=%b", ta[i], tb[i], tc[i],
                  bus1.sum, bus1.c_out, bus1.ovf);
         bus1.out_ready = 1'b1;
         @(posedge clk); #1;
         bus1.out_ready = 1'b0;
      end
   endtask

`ifdef CLA_SEQ_SUB_EN
   task automatic test_sub();
      run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1);
      run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1);
      run_op("add_mode", 16'h0005, 16'h0007, 1'b0, 1'b0);
   endtask
`endif

   initial begin
      bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.c_in = 1'b0; bus4.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0; bus1.out_ready = 1'b0;
`ifdef CLA_SEQ_SUB_EN
      bus4.op_sub = 1'b0;
      bus1.op_sub = 1'b0;
`endif
      test_reset();
      test_ripple();
      test_patterns();
      test_reset_mid_run();
      test_backpressure();
      test_words1();
`ifdef CLA_SEQ_SUB_EN
      test_sub();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
